reg_file_4x8: RTL and testbench
===============================

// Module: reg_file_4x8
// PURPOSE
//  Operand register file that feeds the 4-bit ALU. It holds eight 4-bit registers.
//  It has one synchronous write port and two registered read ports.
//  rd_data1 and rd_data2 drive ALU operand inputs a and b.
//  The ALU's 4-bit result returns on wr_data, so results can be chained.
// PARAMETERS
//  WIDTH     4   data width of each register (must match the ALU operand width)
//  AW        3   address width; DEPTH = 2**AW
//  DEPTH     8   number of registers; must equal 2**AW (not checked in RTL)
//  BYPASS    1   1: a same-cycle write is forwarded to a matching read; 0: the read returns the old value
//  ZERO_REG  0   1: register 0 always reads 0 and writes to it are ignored
// PORTS
//  clk       in   1      clock; all state updates on the rising edge
//  reset     in   1      synchronous, active-high reset
//  wr_en     in   1      write enable
//  wr_addr   in   AW     write address
//  wr_data   in   WIDTH  write data (ALU out)
//  rd_addr1  in   AW     read address, port 1
//  rd_addr2  in   AW     read address, port 2
//  rd_data1  out  WIDTH  registered read data, port 1 (ALU a)
//  rd_data2  out  WIDTH  registered read data, port 2 (ALU b)
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset).
//  - Reset: on a rising edge with reset=1, all DEPTH registers go to 0.
//    rd_data1 and rd_data2 also go to 0. Reset overrides wr_en, so a write in a reset cycle is discarded.
//  - Write: on a rising edge with reset=0 and wr_en=1, mem[wr_addr] <= wr_data.
//    The new value is visible to a plain read from the next edge onward.
//  - Read: on every rising edge with reset=0, rd_dataN <= mem[rd_addrN]. Latency is exactly 1 cycle.
//    The outputs hold between edges and do not change combinationally with address.
//  - Bypass (BYPASS=1): if wr_en=1 and wr_addr==rd_addrN at the same edge, rd_dataN <= wr_data, not the old contents.
//    This applies to each port independently; both ports may hit the same address.
//  - No bypass (BYPASS=0): in the same case rd_dataN <= the old contents of mem[wr_addr].
//  - ZERO_REG=1: a write to address 0 leaves mem[0] at 0. A read of address 0 gives 0, and bypass never applies to address 0.
//  - Both read ports may read the same address in the same cycle. There is no contention.
//  - No stall or handshake. A new read and a new write may be issued every cycle.
//  - Reset in mid-sequence: a write at edge N followed by reset at edge N+1 clears everything.
//    A read of that address at N+2 returns 0.
// TESTING
//  1. Reset high for 2 edges, then read all 8 addresses on both ports -> every rd_data = 4'b0000.
//  2. Write r3=4'b1010, then r5=4'b0101. Then rd_addr1=3, rd_addr2=5 -> one edge later, rd_data1=1010 and rd_data2=0101.
//  3. BYPASS=1, r2=4'b0001: write r2=4'b1111 with rd_addr1=2 at the same edge -> rd_data1=1111 after that edge.
//     Repeat with BYPASS=0 -> rd_data1=0001, then 1111 one edge later.
//  4. wr_en=1 and reset=1 at the same edge, writing r6=4'b0110 -> r6 reads 0000 afterwards.
//     Outputs are 0000 after the reset edge.
//  5. ALU loop: r1=4'b0011, r2=4'b0010, s=3'b010 (add). Write ALU out to r4 -> r4 reads 0101.
//     Then s=3'b110 (multiply low nibble) on r4,r2 -> 1010.
//  6. ZERO_REG=1: write r0=4'b1001 -> rd_data1 for addr 0 = 0000, including in the bypass case.

Source files
------------

// File: rtl/reg_file_4x8.sv
// Operand register file for the 4-bit ALU: eight registers, one write port,
// two registered read ports with optional write-to-read forwarding.
module reg_file_4x8 #(
    parameter int WIDTH    = 4,
    parameter int AW       = 3,
    parameter int DEPTH    = 8,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_zero;
    logic             wr_live;
    logic [WIDTH-1:0] next1;
    logic [WIDTH-1:0] next2;

    // Writes aimed at a hardwired zero register are dropped entirely,
    // so they can neither land in memory nor be forwarded.
    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_live = wr_en && !wr_zero;

    always_comb begin
        next1 = mem[rd_addr1];
        next2 = mem[rd_addr2];
        if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr1))
            next1 = wr_data;
        if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr2))
            next2 = wr_data;
        if ((ZERO_REG != 0) && (rd_addr1 == '0))
            next1 = '0;
        if ((ZERO_REG != 0) && (rd_addr2 == '0))
            next2 = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            if (wr_live)
                mem[wr_addr] <= wr_data;
            rd_data1 <= next1;
            rd_data2 <= next2;
        end
    end

endmodule

// File: tb/tb_reg_file_4x8.sv
// Scoreboard bench for reg_file_4x8: three instances (bypass, no bypass,
// zero register) share one stimulus stream and are checked independently.
module tb_reg_file_4x8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic [3:0] q1 [3];
    logic [3:0] q2 [3];

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        bit              chk;
        logic [2:0][3:0] e1;
        logic [2:0][3:0] e2;
        string           name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_file_4x8 #(.BYPASS(1), .ZERO_REG(0)) u_byp (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(q1[0]), .rd_data2(q2[0])
    );

    reg_file_4x8 #(.BYPASS(0), .ZERO_REG(0)) u_nob (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(q1[1]), .rd_data2(q2[1])
    );

    reg_file_4x8 #(.BYPASS(1), .ZERO_REG(1)) u_zr (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(q1[2]), .rd_data2(q2[2])
    );

    // Reference ALU used to form the chained results written back.
    function automatic logic [3:0] alu(input logic [2:0] s,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
        logic [7:0] p;
        p = a * b;
        case (s)
            3'b010:  return a + b;
            3'b110:  return p[3:0];
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cmp(input string nm, input int inst, input int port,
                       input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s inst%0d port%0d: got %b, expected %b",
                     nm, inst, port, act, req);
        end
    endtask

    // Monitor: each edge's read result appears at the following negedge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                for (int i = 0; i < 3; i++) begin
                    cmp(e.name, i, 1, q1[i], e.e1[i]);
                    cmp(e.name, i, 2, q2[i], e.e2[i]);
                end
            end
        end
    end

    // Expected values per instance: b = bypass, n = no bypass, z = zero reg.
    task automatic step(input bit r, input bit we, input logic [2:0] wa,
                        input logic [3:0] wd, input logic [2:0] a1,
                        input logic [2:0] a2, input bit chk,
                        input logic [3:0] b1, input logic [3:0] b2,
                        input logic [3:0] n1, input logic [3:0] n2,
                        input logic [3:0] z1, input logic [3:0] z2,
                        input string nm);
        exp_t e;
        reset    = r;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
        @(posedge clk);
        e.chk  = chk;
        e.e1   = {z1, n1, b1};
        e.e2   = {z2, n2, b2};
        e.name = nm;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        int guard;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        @(negedge clk);

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "rst1");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 3'(i), 3'(i + 4), 1,
                 0, 0, 0, 0, 0, 0, "rst_read");

        step(0, 1, 3, 4'b1010, 0, 0, 1, 0, 0, 0, 0, 0, 0, "wr_r3");
        step(0, 1, 5, 4'b0101, 0, 0, 1, 0, 0, 0, 0, 0, 0, "wr_r5");
        step(0, 0, 0, 0, 3, 5, 1,
             4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101, "rd_r3_r5");

        step(0, 1, 2, 4'b0001, 3, 5, 1,
             4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101, "wr_r2");
        step(0, 1, 2, 4'b1111, 2, 2, 1,
             4'b1111, 4'b1111, 4'b0001, 4'b0001, 4'b1111, 4'b1111, "bypass");
        step(0, 0, 0, 0, 2, 2, 1,
             4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, "after_byp");

        step(1, 1, 6, 4'b0110, 3, 5, 1, 0, 0, 0, 0, 0, 0, "rst_wr");
        step(0, 0, 0, 0, 6, 3, 1, 0, 0, 0, 0, 0, 0, "rd_after_rst");

        step(0, 1, 1, 4'b0011, 0, 0, 1, 0, 0, 0, 0, 0, 0, "wr_r1");
        step(0, 1, 2, 4'b0010, 1, 2, 1,
             4'b0011, 4'b0010, 4'b0011, 4'b0000, 4'b0011, 4'b0010, "wr_r2b");
        step(0, 0, 0, 0, 1, 2, 1,
             4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010, "rd_ops");
        step(0, 1, 4, alu(3'b010, 4'b0011, 4'b0010), 4, 2, 1,
             4'b0101, 4'b0010, 4'b0000, 4'b0010, 4'b0101, 4'b0010, "alu_add");
        step(0, 1, 7, alu(3'b110, 4'b0101, 4'b0010), 4, 2, 1,
             4'b0101, 4'b0010, 4'b0101, 4'b0010, 4'b0101, 4'b0010, "alu_mul");
        step(0, 0, 0, 0, 7, 4, 1,
             4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101, "rd_chain");

        step(0, 1, 0, 4'b1001, 0, 0, 1,
             4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "zero_byp");
        step(0, 0, 0, 0, 0, 3, 1,
             4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, "zero_rd");

        step(0, 1, 5, 4'b1100, 0, 0, 1,
             4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000, "wr_r5b");
        step(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, "mid_rst");
        step(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, "rd_mid_rst");

        wr_en = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
